// File: rtl/shift_reg_usr_if.sv
// rtl/shift_reg_usr_if.sv - control, data and burst handshake bundle for shift_reg_usr
interface shift_reg_usr_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
);
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] din;
    logic             sin_l;
    logic             sin_r;
    logic             burst_start;
    logic [CNT_W-1:0] burst_len;
    logic [WIDTH-1:0] q;
    logic             sout_l;
    logic             sout_r;
    logic             busy;
    logic             done;

    modport master (
        output en, mode, din, sin_l, sin_r, burst_start, burst_len,
        input  q, sout_l, sout_r, busy, done
    );

    modport slave (
        input  en, mode, din, sin_l, sin_r, burst_start, burst_len,
        output q, sout_l, sout_r, busy, done
    );
endinterface

// File: rtl/shift_reg_usr.sv
// rtl/shift_reg_usr.sv - universal shift register with auto-shift burst engine
// Rotate modes are built only when SHIFT_REG_USR_ROTATE_EN is defined.
module shift_reg_usr #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    shift_reg_usr_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_SHR  = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_ROR  = 3'b101;
    localparam logic [2:0] M_CLR  = 3'b110;

    typedef enum logic {IDLE, BURST} state_t;

    state_t           state;
    logic [WIDTH-1:0] q_r;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       lmode;
    logic             busy_r;
    logic             done_r;

    function automatic logic [WIDTH-1:0] apply_mode(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] d,
        input logic             sl,
        input logic             sr
    );
        logic [WIDTH-1:0] nxt;
        nxt = cur;
        case (m)
            M_LOAD: nxt = d;
            M_SHL:  nxt = {cur[WIDTH-2:0], sr};
            M_SHR:  nxt = {sl, cur[WIDTH-1:1]};
`ifdef SHIFT_REG_USR_ROTATE_EN
            M_ROL:  nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
            M_ROR:  nxt = {cur[0], cur[WIDTH-1:1]};
`endif
            M_CLR:  nxt = '0;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

    function automatic logic is_burst_mode(input logic [2:0] m);
`ifdef SHIFT_REG_USR_ROTATE_EN
        return (m == M_SHL) || (m == M_SHR) || (m == M_ROL) || (m == M_ROR);
`else
        return (m == M_SHL) || (m == M_SHR);
`endif
    endfunction

    // done is a one-cycle pulse and clears even while en is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            q_r    <= '0;
            cnt    <= '0;
            lmode  <= 3'b000;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (bus.en) begin
                case (state)
                    IDLE: begin
                        if (bus.burst_start && (bus.burst_len != '0) && is_burst_mode(bus.mode)) begin
                            state  <= BURST;
                            cnt    <= bus.burst_len;
                            lmode  <= bus.mode;
                            busy_r <= 1'b1;
                        end else begin
                            q_r <= apply_mode(bus.mode, q_r, bus.din, bus.sin_l, bus.sin_r);
                        end
                    end
                    BURST: begin
                        q_r <= apply_mode(lmode, q_r, bus.din, bus.sin_l, bus.sin_r);
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state  <= IDLE;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.q      = q_r;
    assign bus.sout_l = q_r[WIDTH-1];
    assign bus.sout_r = q_r[0];
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
endmodule

// File: tb/tb_shift_reg_usr.sv
// tb/tb_shift_reg_usr.sv - directed and randomized checks of shift_reg_usr against an arithmetic model
module tb_shift_reg_usr;
    localparam int W = 8;
    localparam int MODV = 256;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    shift_reg_usr_if #(.WIDTH(W)) bus ();

    shift_reg_usr #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

`ifdef SHIFT_REG_USR_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    // Model: register value as an integer, remaining burst steps, latched mode
    int unsigned m_q;
    int          m_rem;
    int          m_lmode;
    bit          m_done;
    int          done_seen;

    function automatic int unsigned mdl_apply(int m, int unsigned cur, bit sl, bit sr, int unsigned d);
        case (m)
            1: return d;
            2: return (cur * 2 + sr) % MODV;
            3: return cur / 2 + sl * (MODV / 2);
            4: return ROT ? (cur * 2) % MODV + cur / (MODV / 2) : cur;
            5: return ROT ? cur / 2 + (cur % 2) * (MODV / 2) : cur;
            6: return 0;
            default: return cur;
        endcase
    endfunction

    function automatic bit mdl_burst_ok(int m);
        return (m == 2) || (m == 3) || (ROT && (m == 4 || m == 5));
    endfunction

    task automatic chk(string tag, int unsigned obs, int unsigned exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(string tag);
        chk({tag, ".q"}, 32'(bus.q), m_q);
        chk({tag, ".busy"}, 32'(bus.busy), (m_rem > 0) ? 1 : 0);
        chk({tag, ".done"}, 32'(bus.done), 32'(m_done));
        chk({tag, ".sout_l"}, 32'(bus.sout_l), m_q / (MODV / 2));
        chk({tag, ".sout_r"}, 32'(bus.sout_r), m_q % 2);
    endtask

    task automatic step_cycle(string tag);
        bit nd;
        @(posedge clk);
        nd = 1'b0;
        if (bus.en) begin
            if (m_rem > 0) begin
                m_q = mdl_apply(m_lmode, m_q, bus.sin_l, bus.sin_r, bus.din);
                m_rem--;
                if (m_rem == 0) nd = 1'b1;
            end else if (bus.burst_start && bus.burst_len != 0 && mdl_burst_ok(int'(bus.mode))) begin
                m_rem   = int'(bus.burst_len);
                m_lmode = int'(bus.mode);
            end else begin
                m_q = mdl_apply(int'(bus.mode), m_q, bus.sin_l, bus.sin_r, bus.din);
            end
        end
        m_done = nd;
        @(negedge clk);
        if (bus.done) done_seen++;
        chk_all(tag);
    endtask

    task automatic do_reset(string tag);
        rst = 1'b0;
        #1;
        m_q = 0; m_rem = 0; m_lmode = 0; m_done = 1'b0;
        chk_all(tag);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic set_in(bit e, logic [2:0] m, logic [7:0] d, bit sl, bit sr, bit bs, logic [3:0] bl);
        bus.en = e; bus.mode = m; bus.din = d; bus.sin_l = sl; bus.sin_r = sr;
        bus.burst_start = bs; bus.burst_len = bl;
    endtask

    initial begin
        set_in(1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
        m_q = 0; m_rem = 0; m_lmode = 0; m_done = 1'b0; done_seen = 0;
        #2;
        do_reset("reset");

        set_in(1'b1, 3'b001, 8'hA5, 1'b0, 1'b0, 1'b0, 4'd0);
        step_cycle("load");
        chk("load_a5", 32'(bus.q), 32'h0A5);

        set_in(1'b1, 3'b001, 8'h81, 1'b0, 1'b0, 1'b0, 4'd0);
        step_cycle("load81");
        set_in(1'b1, 3'b010, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0);
        step_cycle("shl1");
        chk("shl_03", 32'(bus.q), 32'h03);
        step_cycle("shl2");
        chk("shl_07", 32'(bus.q), 32'h07);

        set_in(1'b1, 3'b001, 8'h81, 1'b0, 1'b0, 1'b0, 4'd0);
        step_cycle("load81b");
        set_in(1'b1, 3'b011, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0);
        step_cycle("shr");
        chk("shr_40", 32'(bus.q), 32'h40);
        chk("shr_sout_r", 32'(bus.sout_r), 0);

        set_in(1'b1, 3'b001, 8'h81, 1'b0, 1'b0, 1'b0, 4'd0);
        step_cycle("load81c");
        set_in(1'b1, 3'b100, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
        step_cycle("rol");
        chk("rol_const", 32'(bus.q), ROT ? 32'h03 : 32'h81);
        set_in(1'b1, 3'b001, 8'h81, 1'b0, 1'b0, 1'b0, 4'd0);
        step_cycle("load81d");
        set_in(1'b1, 3'b101, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
        step_cycle("ror");
        chk("ror_const", 32'(bus.q), ROT ? 32'h0C0 : 32'h81);

        // burst of 3 left shifts with two paused cycles and mode churn while busy
        set_in(1'b1, 3'b001, 8'h01, 1'b0, 1'b0, 1'b0, 4'd0);
        step_cycle("bload");
        done_seen = 0;
        set_in(1'b1, 3'b010, 8'hFF, 1'b0, 1'b0, 1'b1, 4'd3);
        step_cycle("baccept");
        chk("baccept_q", 32'(bus.q), 32'h01);
        set_in(1'b1, 3'b001, 8'hFF, 1'b0, 1'b0, 1'b1, 4'd7);
        step_cycle("bstep1");
        set_in(1'b0, 3'b110, 8'hFF, 1'b0, 1'b0, 1'b0, 4'd0);
        step_cycle("bpause1");
        step_cycle("bpause2");
        set_in(1'b1, 3'b011, 8'hFF, 1'b1, 1'b0, 1'b0, 4'd0);
        step_cycle("bstep2");
        chk("bstep2_busy", 32'(bus.busy), 1);
        set_in(1'b1, 3'b001, 8'hFF, 1'b1, 1'b0, 1'b0, 4'd0);
        step_cycle("bstep3");
        chk("burst_final", 32'(bus.q), 32'h08);
        chk("burst_done", 32'(bus.done), 1);
        set_in(1'b1, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
        step_cycle("bafter");
        step_cycle("bafter2");
        chk("burst_done_count", 32'(done_seen), 1);

        // reset mid-burst: immediate clear, no done afterwards
        set_in(1'b1, 3'b011, 8'h00, 1'b1, 1'b0, 1'b1, 4'd5);
        step_cycle("aaccept");
        set_in(1'b1, 3'b000, 8'h00, 1'b1, 1'b0, 1'b0, 4'd0);
        step_cycle("astep");
        done_seen = 0;
        do_reset("abort");
        step_cycle("apost1");
        step_cycle("apost2");
        chk("abort_no_done", 32'(done_seen), 0);

        // rejected bursts
        set_in(1'b1, 3'b010, 8'h00, 1'b0, 1'b1, 1'b1, 4'd0);
        step_cycle("len0");
        chk("len0_busy", 32'(bus.busy), 0);
        set_in(1'b1, 3'b001, 8'h5A, 1'b0, 1'b0, 1'b1, 4'd4);
        step_cycle("loadburst");
        chk("loadburst_q", 32'(bus.q), 32'h5A);
        chk("loadburst_busy", 32'(bus.busy), 0);

        // burst longer than the register width
        set_in(1'b1, 3'b011, 8'h00, 1'b1, 1'b0, 1'b1, 4'd11);
        step_cycle("long_acc");
        for (int i = 0; i < 11; i++) step_cycle("long_step");
        chk("long_q", 32'(bus.q), 32'h0FF);

        for (int i = 0; i < 600; i++) begin
            set_in(($urandom_range(0, 9) != 0), 3'($urandom_range(0, 7)), 8'($urandom),
                   1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                   4'($urandom_range(0, 12)));
            step_cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/shift_reg_usr.md
# shift_reg_usr

Parametrised universal shift register: the successor to the team's single-bit D flip-flop, generalised to WIDTH bits. It adds parallel load, left/right shift, optional rotate, synchronous clear and an auto-shift burst engine with a busy/done handshake. It serves as a general storage and serialisation element in datapaths and serial-interface front ends.

## Interface
- WIDTH, 8, register width in bits (≥2)
- CNT_W, $clog2(WIDTH)+1, burst length counter width (derived; do not override)

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- en  input  1  clock enable; gates every state change except reset
- mode  input  3  operation select (see Operation)
- din  input  WIDTH  parallel load data
- sin_l  input  1  serial input entering at the MSB on right shift
- sin_r  input  1  serial input entering at the LSB on left shift
- burst_start  input  1  request an automatic multi-step shift
- burst_len  input  CNT_W  number of steps in the burst
- q  output  WIDTH  register contents
- sout_l  output  1  q[WIDTH-1], combinational from q
- sout_r  output  1  q[0], combinational from q
- busy  output  1  burst in progress
- done  output  1  one-cycle pulse when a burst completes

## Operation
- Reset (rst=0, asynchronous): q=0, busy=0, done=0, counter=0, latched mode=000, state IDLE.
- Mode codes, applied on a clock edge with en=1:
  - 000: hold
  - 001: load, q<=din
  - 010: shift left, q<={q[W-2:0],sin_r}
  - 011: shift right, q<={sin_l,q[W-1:1]}
  - 100: rotate left, q<={q[W-2:0],q[W-1]}
  - 101: rotate right, q<={q[0],q[W-1:1]}
  - 110: clear, q<=0
  - 111: hold (reserved)
- en=0: q, counter and state frozen. done still clears.
- FSM states: IDLE and BURST.
  - IDLE to BURST: en=1, burst_start=1, burst_len≠0, and mode in 010..101. The burst mode and burst_len are latched. The accept cycle itself executes no step; q holds.
  - In IDLE, burst_start with burst_len=0 or a non-shift mode is ignored and the mode executes normally.
  - In BURST, the mode input and burst_start are ignored. Each en=1 cycle performs one step of the latched mode (serial inputs are sampled live) and decrements the counter.
  - BURST to IDLE: on the step that takes the counter from 1 to 0. done=1 on the following cycle.
- burst_len may exceed WIDTH. Steps continue; a shift then fills q entirely with serial input.

## Timing
- Every q update is visible one clock after the sampling edge. Latency is 1 cycle for every mode.
- busy rises the cycle after accept and stays high for exactly burst_len en-qualified cycles.
- done is registered. It is high for exactly one cycle, coincident with the first cycle busy=0.
- Asserting rst mid-burst aborts immediately: q=0, busy=0, and done is never pulsed.
- A burst_start coincident with the done cycle is accepted normally, because the FSM is in IDLE.
- sout_l and sout_r track q with no added delay.

## Configuration
- Macro SHIFT_REG_USR_ROTATE_EN.
- Defined: modes 100 and 101 rotate as specified and are valid burst modes.
- Undefined: modes 100 and 101 behave as hold and are rejected as burst modes (the burst_start is ignored). No rotate logic is synthesised.

## Test plan
- Reset, then load: rst=0 gives q=0x00, busy=0, done=0. Then en=1, mode=001, din=0xA5 gives q=0xA5 after one edge.
- Shift and serial outputs: q=0x81, mode=010, sin_r=1 gives q=0x03, then 0x07. With q=0x81, mode=011, sin_l=0 gives q=0x40, and sout_r follows the new q[0].
- Rotate (macro defined): q=0x81, mode=100 gives q=0x03. With mode=101 from 0x81 gives q=0xC0. With the macro undefined, the same stimulus leaves q=0x81.
- Burst with pauses: q=0x01, mode=010, sin_r=0, burst_start with burst_len=3, en deasserted for 2 cycles mid-burst. Required: busy high for 3 enabled cycles, final q=0x08, a single done pulse, and mode changes during busy have no effect.
- Abort and rejection: rst=0 during a burst gives immediate q=0, busy=0 and no done. burst_len=0 gives no busy. mode=001 with burst_start loads din and does not set busy.
